// File: rtl/ysyx_23060201_mem_arb_pkg.sv
// ysyx_23060201_mem_arb_pkg: FSM states, owner encoding and IFU fetch mask shared by the memory arbiter
package ysyx_23060201_mem_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
    typedef enum logic {OWN_IFU = 1'b0, OWN_LSU = 1'b1} owner_t;
    localparam logic [7:0] IFU_MASK = 8'h0F;
endpackage

// File: rtl/ysyx_23060201_mem_delay.sv
// ysyx_23060201_mem_delay: loadable down-counter emulating fixed memory latency, done when it reaches zero
module ysyx_23060201_mem_delay #(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_done
);
    localparam int CW = $clog2(LATENCY + 1);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else if (i_load) r_cnt <= CW'(LATENCY - 1);
        else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
    assign o_done = r_cnt == '0;
endmodule

// File: rtl/ysyx_23060201_mem_arb.sv
// ysyx_23060201_mem_arb: IFU/LSU arbiter and latency sequencer in front of the data memory.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise LSU wins ties.
module ysyx_23060201_mem_arb
    import ysyx_23060201_mem_arb_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int LATENCY        = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ifu_req_valid,
    output logic                      ifu_req_ready,
    input  logic [MEM_ADDR_WIDTH-1:0] ifu_req_addr,
    output logic                      ifu_resp_valid,
    input  logic                      ifu_resp_ready,
    input  logic                      lsu_req_valid,
    output logic                      lsu_req_ready,
    input  logic                      lsu_req_wen,
    input  logic [MEM_ADDR_WIDTH-1:0] lsu_req_addr,
    input  logic [7:0]                lsu_req_mask,
    input  logic [DATA_WIDTH-1:0]     lsu_req_wdata,
    output logic                      lsu_resp_valid,
    input  logic                      lsu_resp_ready,
    output logic [DATA_WIDTH-1:0]     resp_data,
    output logic                      mem_ren,
    output logic [MEM_ADDR_WIDTH-1:0] mem_raddr,
    output logic [7:0]                mem_rmask,
    output logic                      mem_wen,
    output logic [MEM_ADDR_WIDTH-1:0] mem_waddr,
    output logic [7:0]                mem_wmask,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);
    if (LATENCY < 1) begin : g_bad_latency
        $error("ysyx_23060201_mem_arb: LATENCY must be >= 1");
    end
    state_t r_state, w_state_nxt;
    owner_t r_owner;
    logic                      r_wen;
    logic [MEM_ADDR_WIDTH-1:0] r_addr;
    logic [7:0]                r_mask;
    logic [DATA_WIDTH-1:0]     r_wdata, r_resp_data;
    logic w_idle, w_access, w_prio_lsu, w_grant_lsu, w_grant_ifu, w_hs, w_done, w_resp_ok;
`ifdef MEM_ARB_RR_EN
    owner_t r_last;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_last <= OWN_IFU;
        else if (w_hs) r_last <= w_grant_lsu ? OWN_LSU : OWN_IFU;
    end
    assign w_prio_lsu = r_last == OWN_IFU;
`else
    assign w_prio_lsu = 1'b1;
`endif
    assign w_idle        = r_state == IDLE && !rst;
    assign w_access      = r_state == ACCESS;
    assign w_grant_lsu   = w_idle && lsu_req_valid && (!ifu_req_valid || w_prio_lsu);
    assign w_grant_ifu   = w_idle && ifu_req_valid && !w_grant_lsu;
    assign w_hs          = w_grant_lsu || w_grant_ifu;
    assign w_resp_ok     = r_owner == OWN_LSU ? lsu_resp_ready : ifu_resp_ready;
    assign lsu_req_ready = w_grant_lsu;
    assign ifu_req_ready = w_grant_ifu;
    ysyx_23060201_mem_delay #(.LATENCY(LATENCY)) u_delay (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_hs),
        .i_dec  (w_access),
        .o_done (w_done)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= OWN_IFU;
            r_wen       <= 1'b0;
            r_addr      <= '0;
            r_mask      <= '0;
            r_wdata     <= '0;
            r_resp_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_owner <= w_grant_lsu ? OWN_LSU : OWN_IFU;
                r_wen   <= w_grant_lsu && lsu_req_wen;
                r_addr  <= w_grant_lsu ? lsu_req_addr : ifu_req_addr;
                r_mask  <= w_grant_lsu ? lsu_req_mask : IFU_MASK;
                r_wdata <= lsu_req_wdata;
            end
            if (w_access && w_done) r_resp_data <= r_wen ? '0 : mem_rdata;
        end
    end
    always_comb begin
        w_state_nxt    = r_state;
        mem_ren        = 1'b0;
        mem_wen        = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        w_state_nxt    = (r_state == IDLE && w_hs) ? ACCESS :
                         (w_access && w_done) ? RESP :
                         (r_state == RESP && w_resp_ok) ? IDLE : r_state;
        mem_ren        = w_access && !r_wen;
        mem_wen        = w_access && r_wen && w_done;
        ifu_resp_valid = r_state == RESP && r_owner == OWN_IFU;
        lsu_resp_valid = r_state == RESP && r_owner == OWN_LSU;
    end
    assign resp_data = r_resp_data;
    assign mem_raddr = r_addr;
    assign mem_rmask = r_mask;
    assign mem_waddr = r_addr;
    assign mem_wmask = r_mask;
    assign mem_wdata = r_wdata;
endmodule

// File: tb/tb_ysyx_23060201_mem_arb.sv
// tb_ysyx_23060201_mem_arb: directed checks on a LATENCY=1 and a LATENCY=4 arbiter, each with its own memory model
module tb_ysyx_23060201_mem_arb;
    localparam int AW = 32;
    localparam int DW = 32;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic init;
    logic rst [2];
    logic ifu_req_valid [2], ifu_req_ready [2], ifu_resp_valid [2], ifu_resp_ready [2];
    logic lsu_req_valid [2], lsu_req_ready [2], lsu_req_wen [2], lsu_resp_valid [2], lsu_resp_ready [2];
    logic mem_ren [2], mem_wen [2];
    logic [AW-1:0] ifu_req_addr [2], lsu_req_addr [2], mem_raddr [2], mem_waddr [2];
    logic [7:0] lsu_req_mask [2], mem_rmask [2], mem_wmask [2];
    logic [DW-1:0] lsu_req_wdata [2], resp_data [2], mem_wdata [2], mem_rdata [2];
    int total = 0;
    int bad = 0;
    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [DW-1:0] mem [256];
        int wen_cnt;
        int both_cnt;
        ysyx_23060201_mem_arb #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(g == 0 ? 1 : 4)) u_dut (
            .clk(clk), .rst(rst[g]),
            .ifu_req_valid(ifu_req_valid[g]), .ifu_req_ready(ifu_req_ready[g]), .ifu_req_addr(ifu_req_addr[g]),
            .ifu_resp_valid(ifu_resp_valid[g]), .ifu_resp_ready(ifu_resp_ready[g]),
            .lsu_req_valid(lsu_req_valid[g]), .lsu_req_ready(lsu_req_ready[g]), .lsu_req_wen(lsu_req_wen[g]),
            .lsu_req_addr(lsu_req_addr[g]), .lsu_req_mask(lsu_req_mask[g]), .lsu_req_wdata(lsu_req_wdata[g]),
            .lsu_resp_valid(lsu_resp_valid[g]), .lsu_resp_ready(lsu_resp_ready[g]), .resp_data(resp_data[g]),
            .mem_ren(mem_ren[g]), .mem_raddr(mem_raddr[g]), .mem_rmask(mem_rmask[g]),
            .mem_wen(mem_wen[g]), .mem_waddr(mem_waddr[g]), .mem_wmask(mem_wmask[g]), .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g])
        );
        assign mem_rdata[g] = mem[mem_raddr[g][9:2]];
        always @(posedge clk) begin
            if (init) begin
                for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + i;
                wen_cnt  <= 0;
                both_cnt <= 0;
            end else begin
                if (mem_wen[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_wmask[g][b]) mem[mem_waddr[g][9:2]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
                    wen_cnt <= wen_cnt + 1;
                end
                if (mem_ren[g] && mem_wen[g]) both_cnt <= both_cnt + 1;
            end
        end
    end
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    function automatic int wcnt(input int k);
        return k == 0 ? g_dut[0].wen_cnt : g_dut[1].wen_cnt;
    endfunction
    task automatic wait_resp(input int k, input bit lsu, output int cyc);
        cyc = 1;
        while (!(lsu ? lsu_resp_valid[k] : ifu_resp_valid[k]) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("resp_timeout", 64'(cyc < 20), 1);
    endtask
    task automatic xact(input int k, input bit lsu, input bit wen, input logic [31:0] addr,
                        input logic [7:0] mask, input logic [31:0] wdata, output int cyc, output logic [31:0] data);
        int n = 0;
        if (lsu) begin
            lsu_req_valid[k] = 1'b1; lsu_req_wen[k] = wen; lsu_req_addr[k] = addr;
            lsu_req_mask[k] = mask; lsu_req_wdata[k] = wdata;
        end else begin
            ifu_req_valid[k] = 1'b1; ifu_req_addr[k] = addr;
        end
        #1;
        while (!(lsu ? lsu_req_ready[k] : ifu_req_ready[k]) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("grant_timeout", 64'(n < 20), 1);
        @(negedge clk);
        lsu_req_valid[k] = 1'b0;
        ifu_req_valid[k] = 1'b0;
        wait_resp(k, lsu, cyc);
        data = resp_data[k];
    endtask
    int cyc;
    logic [31:0] d;
    initial begin
        init = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; ifu_req_valid[k] = 1'b0; lsu_req_valid[k] = 1'b0; lsu_req_wen[k] = 1'b0;
            ifu_req_addr[k] = '0; lsu_req_addr[k] = '0; lsu_req_mask[k] = '0; lsu_req_wdata[k] = '0;
            ifu_resp_ready[k] = 1'b1; lsu_resp_ready[k] = 1'b1;
        end
        repeat (2) @(negedge clk);
        check("rst_ifu_resp_valid", ifu_resp_valid[0], 0);
        check("rst_lsu_resp_valid", lsu_resp_valid[0], 0);
        check("rst_mem_ren", mem_ren[0], 0);
        check("rst_mem_wen", mem_wen[0], 0);
        check("rst_resp_data", resp_data[0], 0);
        init = 1'b0;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        xact(0, 0, 0, 32'h8000_0000, 8'h0F, 0, cyc, d);
        check("ifu_lat", cyc, 2);
        check("ifu_data", d, 32'h1000_0000);
        check("ifu_no_wen", wcnt(0), 0);
        xact(0, 1, 1, 32'h8000_0100, 8'h0F, 32'hDEAD_BEEF, cyc, d);
        check("st_lat", cyc, 2);
        check("st_resp_zero", d, 0);
        check("st_wen_once", wcnt(0), 1);
        xact(0, 1, 0, 32'h8000_0100, 8'h0F, 0, cyc, d);
        check("ld_after_st", d, 32'hDEAD_BEEF);
        xact(0, 1, 1, 32'h8000_0100, 8'h03, 32'hAAAA_5555, cyc, d);
        xact(0, 1, 0, 32'h8000_0100, 8'h0F, 0, cyc, d);
        check("ld_masked", d, 32'hDEAD_5555);
        @(negedge clk);
        ifu_req_valid[0] = 1'b1; ifu_req_addr[0] = 32'h8000_0004;
        lsu_req_valid[0] = 1'b1; lsu_req_wen[0] = 1'b0; lsu_req_addr[0] = 32'h8000_0008; lsu_req_mask[0] = 8'h0F;
        #1;
        check("tie1_lsu_ready", lsu_req_ready[0], 1);
        check("tie1_ifu_ready", ifu_req_ready[0], 0);
        @(negedge clk);
        check("access_ifu_ready", ifu_req_ready[0], 0);
        @(negedge clk);
        check("tie1_lsu_resp", lsu_resp_valid[0], 1);
        check("tie1_data", resp_data[0], 32'h1000_0002);
        check("resp_ifu_ready", ifu_req_ready[0], 0);
        @(negedge clk);
`ifdef MEM_ARB_RR_EN
        check("tie2_lsu_ready", lsu_req_ready[0], 0);
        check("tie2_ifu_ready", ifu_req_ready[0], 1);
`else
        check("tie2_lsu_ready", lsu_req_ready[0], 1);
        check("tie2_ifu_ready", ifu_req_ready[0], 0);
`endif
        lsu_req_valid[0] = 1'b0;
        #1;
        check("ifu_after_lsu_ready", ifu_req_ready[0], 1);
        @(negedge clk);
        ifu_req_valid[0] = 1'b0;
        wait_resp(0, 0, cyc);
        check("ifu_after_lsu_data", resp_data[0], 32'h1000_0001);
        @(negedge clk);
        xact(1, 0, 0, 32'h8000_0010, 8'h0F, 0, cyc, d);
        check("lat4_cyc", cyc, 5);
        check("lat4_data", d, 32'h1000_0004);
        @(negedge clk);
        lsu_resp_ready[1] = 1'b0;
        xact(1, 1, 0, 32'h8000_0014, 8'h0F, 0, cyc, d);
        ifu_req_valid[1] = 1'b1; ifu_req_addr[1] = 32'h8000_0018;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("stall_valid", lsu_resp_valid[1], 1);
            check("stall_data", resp_data[1], 32'h1000_0005);
            check("stall_no_grant", ifu_req_ready[1], 0);
        end
        lsu_resp_ready[1] = 1'b1;
        @(negedge clk);
        #1;
        check("release_grant", ifu_req_ready[1], 1);
        ifu_req_valid[1] = 1'b0;
        @(negedge clk);
        lsu_req_valid[1] = 1'b1; lsu_req_wen[1] = 1'b1; lsu_req_addr[1] = 32'h8000_0020;
        lsu_req_mask[1] = 8'h0F; lsu_req_wdata[1] = 32'h1234_5678;
        @(negedge clk);
        lsu_req_valid[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b1;
        #1;
        check("rst_mid_wen", mem_wen[1], 0);
        check("rst_mid_resp_data", resp_data[1], 0);
        repeat (5) @(negedge clk);
        check("rst_mid_no_write", wcnt(1), 0);
        rst[1] = 1'b0;
        @(negedge clk);
        xact(1, 1, 0, 32'h8000_0020, 8'h0F, 0, cyc, d);
        check("rst_mid_mem_kept", d, 32'h1000_0008);
        check("ren_wen_excl0", g_dut[0].both_cnt, 0);
        check("ren_wen_excl1", g_dut[1].both_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
